// File: rtl/dcache_refill_unit.sv
// Refill engine for L1 data-cache misses: fetches one block as a burst of beats,
// assembles it, and hands it back to the cache controller with a single-cycle resolve pulse.
module dcache_refill_unit #(
  parameter int BLOCK_BITS  = 1024,
  parameter int BEAT_BITS   = 64,
  parameter int ADDR_W      = 32,
  parameter int OFFSET_BITS = 7,
  parameter int BEATS       = BLOCK_BITS / BEAT_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read_repair_request,
  input  logic                    write_repair_request,
  input  logic [ADDR_W-1:0]       missed_addr,
  input  logic [ADDR_W-1:0]       write_missed_addr,
  output logic                    repair_resolved,
  output logic [ADDR_W-1:0]       fill_addr,
  output logic [BLOCK_BITS-1:0]   fill_data,
  output logic [BLOCK_BITS/8-1:0] fill_mask,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_W-1:0]       mem_req_addr,
  output logic [7:0]              mem_req_len,
  input  logic                    mem_resp_valid,
  input  logic [BEAT_BITS-1:0]    mem_resp_data,
  input  logic                    mem_resp_last,
  input  logic                    mem_resp_err,
  output logic                    busy,
  output logic [7:0]              err_count
);

  localparam int                CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int                MASK_BITS = BLOCK_BITS / 8;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFFSET_BITS;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    FILL    = 3'd2,
    RESOLVE = 3'd3,
    COOL    = 3'd4
  } state_t;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return addr & LINE_MASK;
  endfunction

  state_t                 state_r;
  logic [CNT_W-1:0]       beat_cnt_r;
  logic                   err_flag_r;
  logic [ADDR_W-1:0]      line_r;
  logic [BLOCK_BITS-1:0]  block_r;
  logic                   repair_resolved_r;
  logic [ADDR_W-1:0]      fill_addr_r;
  logic [BLOCK_BITS-1:0]  fill_data_r;
  logic [MASK_BITS-1:0]   fill_mask_r;
  logic                   mem_req_valid_r;
  logic [ADDR_W-1:0]      mem_req_addr_r;
  logic                   busy_r;
  logic [7:0]             err_count_r;

  logic [BLOCK_BITS-1:0]  block_merge_s;
  logic                   burst_end_s;
  logic                   burst_bad_s;

  // Current block with the incoming beat merged in, plus burst-end classification.
  always_comb begin
    block_merge_s = block_r;
    block_merge_s[int'(beat_cnt_r) * BEAT_BITS +: BEAT_BITS] = mem_resp_data;
    burst_end_s = mem_resp_last || (beat_cnt_r == LAST_BEAT);
    burst_bad_s = err_flag_r || mem_resp_err || (beat_cnt_r != LAST_BEAT);
  end

  // Refill state machine with all outputs registered on the transitions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r           <= IDLE;
      beat_cnt_r        <= '0;
      err_flag_r        <= 1'b0;
      line_r            <= '0;
      block_r           <= '0;
      repair_resolved_r <= 1'b0;
      fill_addr_r       <= '0;
      fill_data_r       <= '0;
      fill_mask_r       <= '0;
      mem_req_valid_r   <= 1'b0;
      mem_req_addr_r    <= '0;
      busy_r            <= 1'b0;
      err_count_r       <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          // Read wins a tie; a losing write must be re-asserted by the controller.
          if (read_repair_request) begin
            line_r          <= line_align(missed_addr);
            mem_req_addr_r  <= line_align(missed_addr);
            mem_req_valid_r <= 1'b1;
            busy_r          <= 1'b1;
            state_r         <= REQ;
          end else if (write_repair_request) begin
            line_r          <= line_align(write_missed_addr);
            mem_req_addr_r  <= line_align(write_missed_addr);
            mem_req_valid_r <= 1'b1;
            busy_r          <= 1'b1;
            state_r         <= REQ;
          end
        end
        REQ: begin
          if (mem_req_valid_r && mem_req_ready) begin
            mem_req_valid_r <= 1'b0;
            beat_cnt_r      <= '0;
            err_flag_r      <= 1'b0;
            state_r         <= FILL;
          end
        end
        FILL: begin
          if (mem_resp_valid) begin
            block_r    <= block_merge_s;
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            err_flag_r <= err_flag_r | mem_resp_err;
            if (burst_end_s) begin
              if (burst_bad_s) begin
                if (err_count_r != 8'hFF) begin
                  err_count_r <= err_count_r + 8'd1;
                end
                mem_req_addr_r  <= line_r;
                mem_req_valid_r <= 1'b1;
                state_r         <= REQ;
              end else begin
                repair_resolved_r <= 1'b1;
                fill_addr_r       <= line_r;
                fill_data_r       <= block_merge_s;
                fill_mask_r       <= {MASK_BITS{1'b1}};
                state_r           <= RESOLVE;
              end
            end
          end
        end
        RESOLVE: begin
          repair_resolved_r <= 1'b0;
          fill_mask_r       <= '0;
          state_r           <= COOL;
        end
        COOL: begin
          // The controller may still hold its request for a cycle after resolve.
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          repair_resolved_r <= 1'b0;
          fill_mask_r       <= '0;
          mem_req_valid_r   <= 1'b0;
          busy_r            <= 1'b0;
          state_r           <= IDLE;
        end
      endcase
    end
  end

  assign repair_resolved = repair_resolved_r;
  assign fill_addr       = fill_addr_r;
  assign fill_data       = fill_data_r;
  assign fill_mask       = fill_mask_r;
  assign mem_req_valid   = mem_req_valid_r;
  assign mem_req_addr    = mem_req_addr_r;
  assign mem_req_len     = 8'(BEATS - 1);
  assign busy            = busy_r;
  assign err_count       = err_count_r;

endmodule

// File: tb/tb_dcache_refill_unit.sv
// Directed bench for dcache_refill_unit: table-driven refills plus multi-cycle corner sequences.
module tb_dcache_refill_unit;

  logic          clk = 1'b0;
  logic          rst;
  logic          read_repair_request;
  logic          write_repair_request;
  logic [31:0]   missed_addr;
  logic [31:0]   write_missed_addr;
  logic          repair_resolved;
  logic [31:0]   fill_addr;
  logic [1023:0] fill_data;
  logic [127:0]  fill_mask;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [31:0]   mem_req_addr;
  logic [7:0]    mem_req_len;
  logic          mem_resp_valid;
  logic [63:0]   mem_resp_data;
  logic          mem_resp_last;
  logic          mem_resp_err;
  logic          busy;
  logic [7:0]    err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_err  = 0;

  always #5 clk = ~clk;

  dcache_refill_unit dut (
    .clk                  (clk),
    .rst                  (rst),
    .read_repair_request  (read_repair_request),
    .write_repair_request (write_repair_request),
    .missed_addr          (missed_addr),
    .write_missed_addr    (write_missed_addr),
    .repair_resolved      (repair_resolved),
    .fill_addr            (fill_addr),
    .fill_data            (fill_data),
    .fill_mask            (fill_mask),
    .mem_req_valid        (mem_req_valid),
    .mem_req_ready        (mem_req_ready),
    .mem_req_addr         (mem_req_addr),
    .mem_req_len          (mem_req_len),
    .mem_resp_valid       (mem_resp_valid),
    .mem_resp_data        (mem_resp_data),
    .mem_resp_last        (mem_resp_last),
    .mem_resp_err         (mem_resp_err),
    .busy                 (busy),
    .err_count            (err_count)
  );

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] exp_line;
    logic [63:0] seed;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  // Present a request for one cycle; returns in the first REQ cycle.
  task automatic start_req(input logic is_wr, input logic [31:0] addr);
    check("idle_no_req", mem_req_valid, 1'b0);
    read_repair_request  = !is_wr;
    write_repair_request = is_wr;
    missed_addr          = addr;
    write_missed_addr    = addr;
    tick();
    read_repair_request  = 1'b0;
    write_repair_request = 1'b0;
  endtask

  // Hold ready low for 'stall' cycles, then accept; returns in the first FILL cycle.
  task automatic accept(input int stall, input logic [31:0] exp_line);
    for (int i = 0; i < stall; i++) begin
      mem_req_ready = 1'b0;
      check("req_valid_stall", mem_req_valid, 1'b1);
      check("req_addr_stall", mem_req_addr, exp_line);
      tick();
    end
    check("req_valid", mem_req_valid, 1'b1);
    check("req_addr", mem_req_addr, exp_line);
    check("req_len", mem_req_len, 8'd15);
    check("busy_req", busy, 1'b1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("req_valid_drop", mem_req_valid, 1'b0);
  endtask

  // Drive n back-to-back beats with data seed+i; err/last flagged on the given indices.
  task automatic beats(input logic [63:0] seed, input int n, input int err_idx, input int last_idx);
    for (int i = 0; i < n; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = seed + 64'(i);
      mem_resp_err   = (i == err_idx);
      mem_resp_last  = (i == last_idx);
      check("no_early_resolve", repair_resolved, 1'b0);
      tick();
    end
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
    mem_resp_last  = 1'b0;
    mem_resp_data  = 64'd0;
  endtask

  // Called in the RESOLVE cycle; walks through COOL into IDLE.
  task automatic expect_resolve(input logic [31:0] exp_line, input logic [63:0] seed);
    check("resolved", repair_resolved, 1'b1);
    check("fill_addr", fill_addr, exp_line);
    check("fill_mask_ones", &fill_mask, 1'b1);
    check("fill_beat0", fill_data[63:0], seed);
    check("fill_beat7", fill_data[511:448], seed + 64'd7);
    check("fill_beat15", fill_data[1023:960], seed + 64'd15);
    tick();
    check("resolve_pulse_end", repair_resolved, 1'b0);
    check("fill_mask_zero", |fill_mask, 1'b0);
    check("fill_data_hold", fill_data[1023:960], seed + 64'd15);
    check("fill_addr_hold", fill_addr, exp_line);
    check("busy_cool", busy, 1'b1);
    check("cool_no_req", mem_req_valid, 1'b0);
    tick();
    check("busy_idle", busy, 1'b0);
    check("idle_no_req2", mem_req_valid, 1'b0);
  endtask

  task automatic expect_retry(input logic [31:0] exp_line);
    check("retry_no_resolve", repair_resolved, 1'b0);
    check("retry_valid", mem_req_valid, 1'b1);
    check("retry_addr", mem_req_addr, exp_line);
    check("err_count", err_count, 64'(exp_err));
  endtask

  initial begin
    vecs[0] = '{is_wr: 1'b0, addr: 32'h0000_12F4, exp_line: 32'h0000_1280, seed: 64'd0};
    vecs[1] = '{is_wr: 1'b1, addr: 32'hDEAD_BEEF, exp_line: 32'hDEAD_BE80, seed: 64'h1111_0000_0000_0100};
    vecs[2] = '{is_wr: 1'b0, addr: 32'h0000_007F, exp_line: 32'h0000_0000, seed: 64'hFFFF_FFFF_FFFF_FFF0};
    vecs[3] = '{is_wr: 1'b1, addr: 32'hFFFF_FFFF, exp_line: 32'hFFFF_FF80, seed: 64'h0123_4567_89AB_CDEF};

    rst = 1'b0;
    read_repair_request  = 1'b0;
    write_repair_request = 1'b0;
    missed_addr          = 32'd0;
    write_missed_addr    = 32'd0;
    mem_req_ready        = 1'b0;
    mem_resp_valid       = 1'b0;
    mem_resp_data        = 64'd0;
    mem_resp_last        = 1'b0;
    mem_resp_err         = 1'b0;
    tick();
    tick();
    check("rst_resolved", repair_resolved, 1'b0);
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err_count", err_count, 8'd0);
    check("rst_fill_mask", |fill_mask, 1'b0);
    check("rst_fill_data", |fill_data, 1'b0);
    check("rst_fill_addr", fill_addr, 32'd0);
    check("rst_req_addr", mem_req_addr, 32'd0);
    rst = 1'b1;
    tick();

    // Table: full refills; resolve lands exactly 18 cycles after the request cycle.
    for (int v = 0; v < 4; v++) begin
      start_req(vecs[v].is_wr, vecs[v].addr);
      accept(0, vecs[v].exp_line);
      beats(vecs[v].seed, 16, -1, 15);
      expect_resolve(vecs[v].exp_line, vecs[v].seed);
    end

    // Simultaneous read and write: read first, write only after COOL while still asserted.
    read_repair_request  = 1'b1;
    missed_addr          = 32'h0000_0100;
    write_repair_request = 1'b1;
    write_missed_addr    = 32'h0000_2000;
    tick();
    read_repair_request  = 1'b0;
    accept(0, 32'h0000_0100);
    beats(64'hA000, 16, -1, 15);
    expect_resolve(32'h0000_0100, 64'hA000);
    tick();
    check("write_after_cool", mem_req_valid, 1'b1);
    write_repair_request = 1'b0;
    accept(0, 32'h0000_2000);
    beats(64'hB000, 16, -1, 15);
    expect_resolve(32'h0000_2000, 64'hB000);

    // Ready held low for 5 cycles.
    start_req(1'b0, 32'h0000_3FFF);
    accept(5, 32'h0000_3F80);
    check("busy_fill", busy, 1'b1);
    beats(64'hC000, 16, -1, 15);
    expect_resolve(32'h0000_3F80, 64'hC000);

    // Bus error on beat 3: burst consumed, retried, then clean.
    start_req(1'b0, 32'h0000_4321);
    accept(0, 32'h0000_4300);
    beats(64'hD000, 16, 3, 15);
    bump_err();
    expect_retry(32'h0000_4300);
    accept(0, 32'h0000_4300);
    beats(64'hD100, 16, -1, 15);
    expect_resolve(32'h0000_4300, 64'hD100);

    // Early last on beat 9 counts as an error.
    start_req(1'b1, 32'h0ABC_DEF0);
    accept(0, 32'h0ABC_DE80);
    beats(64'hE000, 10, -1, 9);
    bump_err();
    expect_retry(32'h0ABC_DE80);

    // 300 forced one-beat failures saturate the counter.
    for (int k = 0; k < 300; k++) begin
      accept(0, 32'h0ABC_DE80);
      beats(64'hE100, 1, 0, 0);
      bump_err();
    end
    expect_retry(32'h0ABC_DE80);
    check("err_sat", err_count, 8'd255);
    accept(0, 32'h0ABC_DE80);
    beats(64'hE200, 16, -1, 15);
    expect_resolve(32'h0ABC_DE80, 64'hE200);

    // Reset asserted while beat 7 is on the bus.
    start_req(1'b0, 32'h5555_5555);
    accept(0, 32'h5555_5500);
    beats(64'hF000, 7, -1, -1);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'hF007;
    rst = 1'b0;
    #2;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_req_valid", mem_req_valid, 1'b0);
    check("mid_rst_resolved", repair_resolved, 1'b0);
    check("mid_rst_err_count", err_count, 8'd0);
    check("mid_rst_fill_data", |fill_data, 1'b0);
    check("mid_rst_fill_addr", fill_addr, 32'd0);
    check("mid_rst_req_addr", mem_req_addr, 32'd0);
    check("mid_rst_fill_mask", |fill_mask, 1'b0);
    #2;
    rst = 1'b1;
    exp_err = 0;
    tick();
    for (int i = 8; i < 16; i++) begin
      mem_resp_data = 64'hF000 + 64'(i);
      mem_resp_last = (i == 15);
      tick();
      check("drop_resolved", repair_resolved, 1'b0);
      check("drop_busy", busy, 1'b0);
    end
    mem_resp_valid = 1'b0;
    mem_resp_last  = 1'b0;
    tick();
    check("post_rst_resolved", repair_resolved, 1'b0);
    check("post_rst_err_count", err_count, 64'(exp_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_refill_unit.md
Name: dcache_refill_unit

Overview:
- Miss-service stage directly downstream of the L1 data-cache controller's repair interface.
- Accepts a read or write repair request and fetches the missing 1024-bit block from the next memory level as a burst of narrow beats.
- Assembles the beats into one block, then returns it to the controller with a one-cycle repair_resolved pulse, a full-block write mask and a line-aligned address.
- No eviction/writeback; dirty victims are handled elsewhere.

Parameters:
- BLOCK_BITS, 1024, cache block width in bits.
- BEAT_BITS, 64, memory response beat width; must divide BLOCK_BITS.
- ADDR_W, 32, byte address width.
- OFFSET_BITS, 7, log2 of block size in bytes.
- BEATS, BLOCK_BITS/BEAT_BITS (16), derived; beats per refill.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- read_repair_request  in  1  read miss from cache controller.
- write_repair_request  in  1  write miss from cache controller.
- missed_addr  in  ADDR_W  read-miss address.
- write_missed_addr  in  ADDR_W  write-miss address.
- repair_resolved  out  1  one-cycle pulse; fill_* valid this cycle.
- fill_addr  out  ADDR_W  line-aligned refill address.
- fill_data  out  BLOCK_BITS  assembled block.
- fill_mask  out  BLOCK_BITS/8  byte mask; all ones while repair_resolved=1, else 0.
- mem_req_valid  out  1  burst request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  line-aligned burst address.
- mem_req_len  out  8  BEATS-1.
- mem_resp_valid  in  1  response beat valid.
- mem_resp_data  in  BEAT_BITS  beat payload.
- mem_resp_last  in  1  final beat of burst.
- mem_resp_err  in  1  beat carries a bus error.
- busy  out  1  state != IDLE.
- err_count  out  8  saturating count of errored bursts.

Behaviour:
- Reset (rst=0, async): state=IDLE, beat_cnt=0, repair_resolved=0, mem_req_valid=0, fill_mask=0, fill_data=0, fill_addr=0, mem_req_addr=0, err_count=0, busy=0.
- States: IDLE, REQ, FILL, RESOLVE, COOL.
- IDLE:
  - read_repair_request=1: latch {missed_addr[ADDR_W-1:OFFSET_BITS], zeros} into the line register, go to REQ.
  - Else write_repair_request=1: latch write_missed_addr the same way, go to REQ.
  - Both asserted: read wins; the write request is not queued, so the controller must keep asserting it.
  - mem_resp beats arriving in IDLE are dropped.
- REQ:
  - mem_req_valid=1; mem_req_addr=line register; mem_req_len=BEATS-1.
  - Handshake completes on mem_req_valid & mem_req_ready: clear beat_cnt and err_flag, go to FILL.
  - mem_req_valid stays high and the address stays stable until accepted.
- FILL:
  - Each mem_resp_valid writes mem_resp_data into block[beat_cnt*BEAT_BITS +: BEAT_BITS] (beat 0 = lowest bits), then beat_cnt+1.
  - mem_resp_err on any beat sets err_flag.
  - Burst ends on a beat with mem_resp_last=1, or when beat_cnt reaches BEATS-1, whichever comes first.
  - At burst end:
    - If err_flag was set, or will be set by this beat, or last came early (beat_cnt != BEATS-1): err_count+1 (saturates at 255), go to REQ to retry the same line.
    - Otherwise go to RESOLVE.
  - Beats past BEATS are ignored.
- RESOLVE (exactly 1 cycle):
  - repair_resolved=1, fill_addr=line register, fill_data=block, fill_mask=all ones.
  - Then go to COOL.
  - Outside RESOLVE, repair_resolved=0 and fill_mask=0; fill_data and fill_addr hold their last values.
- COOL (1 cycle): ignore requests, because the controller's request may still be high for a cycle after resolve. Then go to IDLE.
- Latency: request accepted in IDLE at cycle t → mem_req_valid at t+1. With ready=1 and back-to-back beats, repair_resolved at t+1+1+BEATS (t+18 at default parameters).
- Reset mid-burst: abort immediately; no repair_resolved; the in-flight burst remainder is dropped in IDLE.

Test Plan:
- Read miss, missed_addr=0x0000_12F4, ready=1, 16 beats with data = beat index → mem_req_addr=0x0000_1280, len=15; repair_resolved for one cycle at t+18; fill_data[63:0]=0, fill_data[1023:960]=15, fill_mask=all ones.
- Simultaneous read (0x100) and write (0x2000) requests → mem_req_addr=0x100; write request is serviced only after COOL, and only if still asserted.
- mem_req_ready held low for 5 cycles → mem_req_valid stays high with a stable address; FILL entered on the 6th cycle.
- mem_resp_err on beat 3 → all 16 beats consumed, no resolve, err_count=1, request re-issued to the same address; a clean retry then resolves.
- mem_resp_last on beat 9 → treated as an error and retried; err_count increments. 300 forced errors → err_count saturates at 255.
- rst pulsed low during beat 7 → all outputs return to reset values immediately; remaining beats ignored; no repair_resolved.
